// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared LC-3b hazard/forwarding types.
// Slot bundles, forward-select and dest-mux encodings.
package lc3b_types;

  localparam int NUM_REGS = 8;
  localparam int REG_W = $clog2(NUM_REGS);

  typedef logic [REG_W-1:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } lc3b_fwdsel;

  typedef enum logic [1:0] {
    DEST_ALU  = 2'd0,
    DEST_ADDR = 2'd1,
    DEST_PC   = 2'd2
  } lc3b_destsel;

  typedef struct packed {
    logic        valid;
    lc3b_reg     dest;
    logic        writes;
    logic        is_load;
    lc3b_destsel dest_mux_sel;
  } lc3b_hzslot;

  typedef struct packed {
    lc3b_reg sr1;
    lc3b_reg sr2;
    logic    uses_sr1;
    logic    uses_sr2;
  } lc3b_hzsrc;

  function automatic logic slot_hit(
    input lc3b_hzslot s,
    input lc3b_reg    r
  );
    return s.valid && s.writes && (s.dest == r);
  endfunction

  // EX/MEM wins over MEM/WB; a load in MEM never forwards.
  function automatic lc3b_fwdsel fwd_pick(
    input logic       uses,
    input lc3b_reg    r,
    input lc3b_hzslot mem,
    input lc3b_hzslot wb
  );
    if (!uses)
      return FWD_RF;
    if (slot_hit(mem, r) && !mem.is_load)
      return FWD_EXMEM;
    if (slot_hit(wb, r))
      return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_slot.sv
// One in-flight instruction tag register.
// Holds unless loaded; a bubble loads an empty slot.
import lc3b_types::*;

module hazard_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       bubble,
  input  lc3b_hzslot slot_i,
  output lc3b_hzslot slot_o
);

  lc3b_hzslot slot_d;
  lc3b_hzslot slot_q;

  always_comb begin
    slot_d = slot_q;
    if (load)
      slot_d = bubble ? '0 : slot_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      slot_q <= '0;
    else
      slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX operand forwarding selects and load-use stall.
// Tracks ID/EX, EX/MEM and MEM/WB destination tags.
import lc3b_types::*;

module hazard_forward_ctrl #(
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        iAdvance,
  input  logic                        iFlush,
  input  logic                        iIDValid,
  input  logic [$clog2(NUM_REGS)-1:0] iIDSR1,
  input  logic [$clog2(NUM_REGS)-1:0] iIDSR2,
  input  logic                        iIDUsesSR1,
  input  logic                        iIDUsesSR2,
  input  logic [$clog2(NUM_REGS)-1:0] iIDDest,
  input  logic                        iIDWritesReg,
  input  logic                        iIDIsLoad,
  input  logic [1:0]                  iIDDestMuxSel,
  output logic [1:0]                  oForwardSR1Sel,
  output logic [1:0]                  oForwardSR2Sel,
  output logic [1:0]                  oEXMemDestMuxSel,
  output logic                        oLoadUseStall
);

  lc3b_hzslot id_slot;
  lc3b_hzslot ex_slot;
  lc3b_hzslot mem_slot;
  lc3b_hzslot wb_slot;
  lc3b_hzsrc  id_src;
  lc3b_hzsrc  ex_src_d;
  lc3b_hzsrc  ex_src_q;
  logic       ex_bubble;
  logic       load_use;

  always_comb begin
    id_slot = '0;
    id_slot.valid = 1'b1;
    id_slot.dest = iIDDest;
    id_slot.writes = iIDWritesReg;
    id_slot.is_load = iIDIsLoad;
    id_slot.dest_mux_sel = lc3b_destsel'(iIDDestMuxSel);
    id_src = '0;
    id_src.sr1 = iIDSR1;
    id_src.sr2 = iIDSR2;
    id_src.uses_sr1 = iIDUsesSR1;
    id_src.uses_sr2 = iIDUsesSR2;
  end

  always_comb begin
    load_use = iIDValid && ex_slot.valid
      && ex_slot.writes && ex_slot.is_load
      && ((iIDUsesSR1 && (iIDSR1 == ex_slot.dest))
       || (iIDUsesSR2 && (iIDSR2 == ex_slot.dest)));
    oLoadUseStall = load_use && !iFlush;
  end

  assign ex_bubble = oLoadUseStall || iFlush || !iIDValid;

  hazard_slot u_ex (
    .clk    (clk),
    .reset  (reset),
    .load   (iAdvance),
    .bubble (ex_bubble),
    .slot_i (id_slot),
    .slot_o (ex_slot)
  );

  hazard_slot u_mem (
    .clk    (clk),
    .reset  (reset),
    .load   (iAdvance),
    .bubble (1'b0),
    .slot_i (ex_slot),
    .slot_o (mem_slot)
  );

  hazard_slot u_wb (
    .clk    (clk),
    .reset  (reset),
    .load   (iAdvance),
    .bubble (1'b0),
    .slot_i (mem_slot),
    .slot_o (wb_slot)
  );

  always_comb begin
    ex_src_d = ex_src_q;
    if (iAdvance)
      ex_src_d = ex_bubble ? '0 : id_src;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ex_src_q <= '0;
    else
      ex_src_q <= ex_src_d;
  end

  always_comb begin
    oForwardSR1Sel = fwd_pick(ex_src_q.uses_sr1,
      ex_src_q.sr1, mem_slot, wb_slot);
    oForwardSR2Sel = fwd_pick(ex_src_q.uses_sr2,
      ex_src_q.sr2, mem_slot, wb_slot);
    oEXMemDestMuxSel = mem_slot.valid ?
      mem_slot.dest_mux_sel : DEST_ALU;
  end

  logic mem_load_hit;
  assign mem_load_hit = mem_slot.valid && mem_slot.writes
    && mem_slot.is_load
    && ((ex_src_q.uses_sr1 && ex_src_q.sr1 == mem_slot.dest)
     || (ex_src_q.uses_sr2 && ex_src_q.sr2 == mem_slot.dest));

  a_no_mem_load_fwd: assert property (
    @(posedge clk) disable iff (reset) !mem_load_hit);

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed checks of forwarding selects and stall.
// Vectors hand-derived from LC-3b pipeline sequences.
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       iAdvance;
  logic       iFlush;
  logic       iIDValid;
  logic [2:0] iIDSR1;
  logic [2:0] iIDSR2;
  logic       iIDUsesSR1;
  logic       iIDUsesSR2;
  logic [2:0] iIDDest;
  logic       iIDWritesReg;
  logic       iIDIsLoad;
  logic [1:0] iIDDestMuxSel;
  logic [1:0] oForwardSR1Sel;
  logic [1:0] oForwardSR2Sel;
  logic [1:0] oEXMemDestMuxSel;
  logic       oLoadUseStall;

  int n_checks = 0;
  int n_fail = 0;

  hazard_forward_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .iAdvance         (iAdvance),
    .iFlush           (iFlush),
    .iIDValid         (iIDValid),
    .iIDSR1           (iIDSR1),
    .iIDSR2           (iIDSR2),
    .iIDUsesSR1       (iIDUsesSR1),
    .iIDUsesSR2       (iIDUsesSR2),
    .iIDDest          (iIDDest),
    .iIDWritesReg     (iIDWritesReg),
    .iIDIsLoad        (iIDIsLoad),
    .iIDDestMuxSel    (iIDDestMuxSel),
    .oForwardSR1Sel   (oForwardSR1Sel),
    .oForwardSR2Sel   (oForwardSR2Sel),
    .oEXMemDestMuxSel (oEXMemDestMuxSel),
    .oLoadUseStall    (oLoadUseStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2,
                        input logic [2:0] d, input logic w,
                        input logic ld, input logic [1:0] dm);
    iIDValid = 1'b1;
    iIDSR1 = s1;
    iIDUsesSR1 = u1;
    iIDSR2 = s2;
    iIDUsesSR2 = u2;
    iIDDest = d;
    iIDWritesReg = w;
    iIDIsLoad = ld;
    iIDDestMuxSel = dm;
  endtask

  task automatic id_nop();
    iIDValid = 1'b0;
    iIDSR1 = 3'd0;
    iIDUsesSR1 = 1'b0;
    iIDSR2 = 3'd0;
    iIDUsesSR2 = 1'b0;
    iIDDest = 3'd0;
    iIDWritesReg = 1'b0;
    iIDIsLoad = 1'b0;
    iIDDestMuxSel = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_nop();
    repeat (3) tick();
  endtask

  task automatic check_sels(input string tag, input int s1,
                            input int s2, input int dm);
    check({tag, ".sr1"}, oForwardSR1Sel, s1);
    check({tag, ".sr2"}, oForwardSR2Sel, s2);
    check({tag, ".dm"}, oEXMemDestMuxSel, dm);
  endtask

  initial begin
    reset = 1'b1;
    iAdvance = 1'b1;
    iFlush = 1'b0;
    id_nop();
    #2;
    check_sels("reset", 0, 0, 0);
    check("reset.stall", oLoadUseStall, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ADD R1<-R2,R3 ; ADD R4<-R1,R1
    id_set(3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 2'd0);
    tick();
    id_set(3'd1, 1, 3'd1, 1, 3'd4, 1, 0, 2'd0);
    #1;
    check("t1.stall", oLoadUseStall, 0);
    tick();
    check_sels("t1", 1, 1, 0);

    // freeze three edges with a R4/R1 consumer waiting
    iAdvance = 1'b0;
    id_set(3'd4, 1, 3'd1, 1, 3'd5, 1, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_sels("t4.hold", 1, 1, 0);
    end
    iAdvance = 1'b1;
    tick();
    check_sels("t4.resume", 1, 2, 0);
    drain();
    check_sels("t4.drained", 0, 0, 0);

    // ADD R1 ; NOP ; AND R5<-R1,#3
    id_set(3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 2'd0);
    tick();
    id_nop();
    tick();
    id_set(3'd1, 1, 3'd1, 0, 3'd5, 1, 0, 2'd0);
    tick();
    check_sels("t2", 2, 0, 0);
    drain();

    // LDR R2<-R6 ; ADD R3<-R2,R2
    id_set(3'd6, 1, 3'd0, 0, 3'd2, 1, 1, 2'd1);
    tick();
    id_set(3'd2, 1, 3'd2, 1, 3'd3, 1, 0, 2'd0);
    #1;
    check("t3.stall", oLoadUseStall, 1);
    iAdvance = 1'b0;
    tick();
    check("t3.stall_frozen", oLoadUseStall, 1);
    iAdvance = 1'b1;
    tick();
    check("t3.stall_gone", oLoadUseStall, 0);
    check_sels("t3.bubble", 0, 0, 1);
    tick();
    check_sels("t3.consume", 2, 2, 0);
    check("t3.no_restall", oLoadUseStall, 0);
    drain();

    // load-use hazard with simultaneous flush
    id_set(3'd6, 1, 3'd0, 0, 3'd2, 1, 1, 2'd1);
    tick();
    id_set(3'd2, 1, 3'd2, 1, 3'd3, 1, 0, 2'd0);
    iFlush = 1'b1;
    #1;
    check("t5.stall", oLoadUseStall, 0);
    tick();
    iFlush = 1'b0;
    id_nop();
    #1;
    check_sels("t5.squash", 0, 0, 1);
    check("t5.stall_after", oLoadUseStall, 0);
    drain();

    // ADD R1 ; ADD R1 ; LDR R6<-R1 ; ADD R7<-R6,R6
    id_set(3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 2'd0);
    tick();
    id_set(3'd4, 1, 3'd5, 1, 3'd1, 1, 0, 2'd2);
    tick();
    id_set(3'd1, 1, 3'd0, 0, 3'd6, 1, 1, 2'd1);
    tick();
    id_set(3'd6, 1, 3'd6, 1, 3'd7, 1, 0, 2'd0);
    #1;
    check_sels("t6", 1, 0, 2);
    check("t6.stall", oLoadUseStall, 1);
    reset = 1'b1;
    #1;
    check_sels("t6.reset", 0, 0, 0);
    check("t6.reset_stall", oLoadUseStall, 0);
    @(negedge clk);
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
